fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side controller for the team's synchronous FIFO (`FIFO_SYNC`).
- Drives the FIFO's `rd_en` from its `empty` flag and captures `d_out`.
- Re-presents the words on a registered valid/ready stream at full throughput through a 2-entry output buffer.
- Guarantees the FIFO never sees a read while empty, so its `underflow` never asserts.
- Frames the stream into fixed-length packets with a `last` marker.

## Interface
- `WIDTH`, default 8: data width; must equal the FIFO's `FIFO_WIDTH`.
- `PKT_LEN`, default 4: words per packet; legal range 1 to 2^CNT_W − 1.
- `CNT_W`, default 16: width of the delivered-word counter.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_d_out`  in  WIDTH  FIFO read data; valid the cycle after a pop.
- `fifo_rd_en`  out  1  pop request to the FIFO; combinational.
- `m_valid`  out  1  stream word available; registered.
- `m_data`  out  WIDTH  stream data, head of the buffer; registered.
- `m_last`  out  1  marks the final word of a packet; registered.
- `m_ready`  in  1  downstream accepts the word.
- `words_out`  out  CNT_W  total words accepted downstream; wraps modulo 2^CNT_W.

## Operation
FIFO read model: `fifo_rd_en` high while `fifo_empty` = 0 pops at the next edge E. The popped word is on `fifo_d_out` during the cycle after E and is captured at edge E+1.

State:
- `inflight`: 1 bit. Set when a pop is issued. Cleared when the word is captured.
- `occ`: buffer occupancy in {0, 1, 2}.
- `pkt_cnt`: 0 to PKT_LEN−1.

Occupancy states:
- EMPTY (`occ` = 0): `m_valid` = 0.
- ONE (`occ` = 1) and TWO (`occ` = 2): `m_valid` = 1.

Rules:
- `accept` = `m_valid` & `m_ready`.
- `fifo_rd_en` = !`fifo_empty` & (`occ` + `inflight` − `accept` < 2).
- `fifo_rd_en` is never high while `fifo_empty` = 1.
- The buffer never overflows, because `occ` + `inflight` ≤ 2 always.

Transitions per edge:
- `occ` += `inflight` − `accept`.
- A capture and a pop in the same cycle leave `occ` unchanged.
- From EMPTY, a capture writes the head directly.
- From TWO, `accept` shifts entry 1 into the head.
- Words leave in FIFO order, with no loss and no duplication.

Packet framing:
- `m_last` = `m_valid` & (`pkt_cnt` == PKT_LEN−1).
- On `accept`, `pkt_cnt` advances. It returns to 0 after the last word.
- With PKT_LEN = 1, `m_last` is high on every valid word.

Counter: `words_out` increments by 1 on each `accept`.

Stall behaviour: while `m_valid` = 1 and `m_ready` = 0, `m_data` and `m_last` hold stable.

## Timing
Reset values (asynchronous, immediate on `rst` = 1):
- `m_valid` = 0, `m_data` = 0, `m_last` = 0, `words_out` = 0.
- `inflight` = 0, `occ` = 0, `pkt_cnt` = 0.
- `fifo_rd_en` = 0 while `rst` is high.

Latency:
- `fifo_empty` falls in cycle 0 with the block idle.
- `fifo_rd_en` = 1 in cycle 0, the FIFO pops at edge 1, and the word is captured at edge 2.
- `m_valid` = 1 in cycle 2, giving 2-cycle first-word latency.

Throughput:
- With `m_ready` held at 1 and the FIFO non-empty, one word is delivered per cycle with no bubbles.
- In steady state `occ` = 1 and `inflight` = 1.

Backpressure:
- With `m_ready` = 0, at most 2 further words are popped, then `fifo_rd_en` stays 0.
- When `m_ready` rises, words resume the same cycle.

Boundary conditions:
- FIFO empties mid-stream: buffered words drain, then `m_valid` falls. There are no spurious reads.
- Reset mid-operation: buffered and in-flight words are discarded and the packet counter restarts. The FIFO is reset by the same `rst`, so the two stay consistent.
- `words_out` wraps from all-ones to 0.

## Test plan
- Reset, then write 1,2,3 into the FIFO with `m_ready` = 1 → `m_data` = 1,2,3 on consecutive cycles, first at 2 cycles after `empty` falls. `m_last` on word 4 only once written; `words_out` = 3. `fifo_rd_en` never high while `fifo_empty`.
- Fill the FIFO with 0..7 and hold `m_ready` = 0 for 10 cycles → exactly 2 pops, and `m_data` = 0 stable. Release → 0..7 delivered in 8 consecutive cycles; `m_last` on 3 and 7; FIFO `underflow`/`overflow` never assert.
- Toggle `m_ready` 1,0,1,0 while streaming 0..9 → order preserved with no duplicates. `m_data`/`m_last` stable during stalls; `words_out` = 10.
- Wrap-around: write 8 words, accept 4, write 4 more, accept 8 → output sequence 0..7 then 0..3, with `pkt_cnt` continuing across the gap (`m_last` on the 4th, 8th and 12th words).
- Write 2 and 5, assert `rst` for one cycle while a word is in flight → outputs zero immediately. After release, new data 9 appears alone as the first word with `pkt_cnt` = 0.
- PKT_LEN = 1 build: stream 3 words → `m_last` = 1 on each.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side controller for the synchronous FIFO. It pops words while the
//   FIFO is not empty and captures each word the cycle after the pop. It
//   re-presents the words on a registered valid/ready stream through a
//   2-entry buffer, and frames them into PKT_LEN-word packets.
//
// Parameters
//   WIDTH    data width (must match the FIFO data width)
//   PKT_LEN  words per packet, 1 .. 2^CNT_W-1
//   CNT_W    width of the packet and delivered-word counters
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_d_out  in   FIFO read data, valid the cycle after a pop
//   fifo_rd_en  out  pop request to the FIFO (combinational)
//   m_valid     out  stream word available (registered)
//   m_data      out  stream data, head of the buffer (registered)
//   m_last      out  final word of a packet (registered)
//   m_ready     in   downstream accepts the word
//   words_out   out  total words accepted downstream, wraps
//
// Buffer occupancy FSM
//   state | meaning
//   EMPTY | no word buffered, m_valid low
//   ONE   | head holds the next word
//   TWO   | head and spare both hold words, spare is the younger one
module fifo_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_d_out,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] words_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  occ_t             state_q, state_d;
  logic             inflight_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] spare_q, spare_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             last_q, last_d;
  logic             accept;
  logic [2:0]       level;

  assign accept = (state_q != EMPTY) & m_ready;

  // Words already owned by this block: buffered plus the one in flight.
  assign level = {1'b0, state_q} + {2'b00, inflight_q};

  // A pop is allowed when, after this cycle's accept, at most one word is
  // owned; the popped word then always finds a free buffer slot.
  assign fifo_rd_en = !rst && !fifo_empty && (level < (3'd2 + {2'b00, accept}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      spare_q    <= '0;
      pkt_q      <= '0;
      words_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      head_q     <= head_d;
      spare_q    <= spare_d;
      pkt_q      <= pkt_d;
      words_q    <= words_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    spare_d = spare_q;
    case (state_q)
      EMPTY: begin
        if (inflight_q) begin
          head_d  = fifo_d_out;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({inflight_q, accept})
          2'b10: begin
            spare_d = fifo_d_out;
            state_d = TWO;
          end
          2'b11: head_d = fifo_d_out;
          2'b01: state_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        // Nothing can be in flight while two words are buffered.
        if (accept) begin
          head_d  = spare_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    pkt_d   = pkt_q;
    words_d = words_q;
    if (accept) begin
      words_d = words_q + CNT_ONE;
      if (pkt_q == LAST_IDX) begin
        pkt_d = '0;
      end else begin
        pkt_d = pkt_q + CNT_ONE;
      end
    end
    // m_last is registered, so it is computed from the next-cycle state.
    last_d = (state_d != EMPTY) && (pkt_d == LAST_IDX);
  end

  assign m_valid   = (state_q != EMPTY);
  assign m_data    = head_q;
  assign m_last    = last_q;
  assign words_out = words_q;

endmodule
